// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, derived totals and FSM encoding.
// Shared by the raster timing generator and anything that decodes its counters.
package vga_timing_pkg;

  localparam int H_DISP  = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_DISP  = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  typedef enum logic {
    START = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/vga_timing_gen_clk_en_div.sv
// Rate enable: en_o is a registered one-clk pulse every CLK_DIV clks, first one CLK_DIV clks
// after reset release. Free-running, no backpressure.
module clk_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic en_o
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("clk_en_div: CLK_DIV must be at least 2");
  end

  logic [DW-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      en_o <= 1'b0;
    end else begin
      en_o <= (div == DIV_LAST);
      div  <= (div == DIV_LAST) ? '0 : div + DW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters, valid and syncs all registered and updated together on pclk_en,
// one clk after the enable pulse. No backpressure. Optional frame counter: VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_DISP  = vga_timing_pkg::H_DISP,
  parameter int H_FP    = vga_timing_pkg::H_FP,
  parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int H_BP    = vga_timing_pkg::H_BP,
  parameter int V_DISP  = vga_timing_pkg::V_DISP,
  parameter int V_FP    = vga_timing_pkg::V_FP,
  parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int V_BP    = vga_timing_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pclk_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
`ifdef VGA_FRAME_CNT_EN
  output logic [7:0] frame_cnt,
`endif
  output logic       frame_start
);

  import vga_timing_pkg::*;

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

  if (H_TOT > 1024) begin : g_bad_h
    $error("vga_timing_gen: horizontal total exceeds 1024");
  end
  if (V_TOT > 1024) begin : g_bad_v
    $error("vga_timing_gen: vertical total exceeds 1024");
  end

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISP);
  localparam logic [9:0] V_VIS    = 10'(V_DISP);
  localparam logic [9:0] HS_FIRST = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);

  clk_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en_o  (pclk_en)
  );

  state_t     state;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       fs_nxt;
  logic       h_wrap;
  logic       v_wrap;

  // In START the next position is the held (0,0); the first enable only announces the frame.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_cnt;
    v_nxt  = v_cnt;
    fs_nxt = 1'b1;
    if (state == RUN) begin
      h_nxt  = h_wrap ? '0 : h_cnt + 10'd1;
      if (h_wrap) v_nxt = v_wrap ? '0 : v_cnt + 10'd1;
      fs_nxt = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= START;
      h_cnt       <= '0;
      v_cnt       <= '0;
      valid       <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pclk_en) begin
        state       <= RUN;
        h_cnt       <= h_nxt;
        v_cnt       <= v_nxt;
        valid       <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
        hsync       <= !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
        vsync       <= !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
        frame_start <= fs_nxt;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pclk_en && fs_nxt) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a shrunken raster (15x11, CLK_DIV=4) so whole
// frames fit in a short run; table vectors plus reset, cadence and multi-frame sequences.
module tb_vga_timing_gen;

  localparam int CD = 4;
  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VF = 2, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;  // 15
  localparam int VT = VD + VF + VS + VB;  // 11

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pclk_en, valid, hsync, vsync, frame_start;
  logic [9:0] h_cnt, v_cnt;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vga_timing_gen #(
    .CLK_DIV (CD),
    .H_DISP (HD), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_DISP (VD), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pclk_en     (pclk_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .valid       (valid),
    .hsync       (hsync),
    .vsync       (vsync),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt   (frame_cnt),
`endif
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int k;
    int h;
    int v;
    bit vl;
    bit hs;
    bit vs;
    bit fs;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pclk_en"}, 32'(pclk_en), 0);
    chk({tag, "_h_cnt"}, 32'(h_cnt), 0);
    chk({tag, "_v_cnt"}, 32'(v_cnt), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_hsync"}, 32'(hsync), 1);
    chk({tag, "_vsync"}, 32'(vsync), 1);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
  endtask

  // Ends on the negedge right after the clk in which pclk_en was seen high.
  task automatic step_pixel(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!pclk_en && waited < 4 * CD);
    if (!pclk_en) begin
      checks++;
      errors++;
      $display("FAIL pclk_timeout: got no pclk_en within %0d clks", waited);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pack_dut();
    return {8'd0, h_cnt, v_cnt, valid, hsync, vsync, frame_start};
  endfunction

  function automatic logic [31:0] pack_exp(input int h, input int v, input bit vl,
                                           input bit hs, input bit vs, input bit fs);
    return {8'd0, 10'(h), 10'(v), vl, hs, vs, fs};
  endfunction

  function automatic logic [31:0] model(input int k);
    int h, v;
    h = k % HT;
    v = (k / HT) % VT;
    return pack_exp(h, v, (h < HD) && (v < VD),
                    !(h >= HD + HF && h < HD + HF + HS),
                    !(v >= VD + VF && v < VD + VF + VS),
                    (k % (HT * VT)) == 0);
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, kk, acc, nfs, last_fs;

    //              k    h   v  vl hs vs fs
    tbl[0]  = '{  0,  0,  0, 1, 1, 1, 1};
    tbl[1]  = '{  7,  7,  0, 1, 1, 1, 0};
    tbl[2]  = '{  8,  8,  0, 0, 1, 1, 0};
    tbl[3]  = '{  9,  9,  0, 0, 1, 1, 0};
    tbl[4]  = '{ 10, 10,  0, 0, 0, 1, 0};
    tbl[5]  = '{ 12, 12,  0, 0, 0, 1, 0};
    tbl[6]  = '{ 13, 13,  0, 0, 1, 1, 0};
    tbl[7]  = '{ 14, 14,  0, 0, 1, 1, 0};
    tbl[8]  = '{ 15,  0,  1, 1, 1, 1, 0};
    tbl[9]  = '{ 90,  0,  6, 0, 1, 1, 0};
    tbl[10] = '{119, 14,  7, 0, 1, 1, 0};
    tbl[11] = '{120,  0,  8, 0, 1, 0, 0};
    tbl[12] = '{149, 14,  9, 0, 1, 0, 0};
    tbl[13] = '{150,  0, 10, 0, 1, 1, 0};
    tbl[14] = '{164, 14, 10, 0, 1, 1, 0};
    tbl[15] = '{165,  0,  0, 1, 1, 1, 1};

    // Power-up reset, then enable cadence and the first frame_start.
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("pclk_en_cadence", 32'(pclk_en), 32'(i % CD == 0));
      if (i == 5) begin
        chk("first_fs", 32'(frame_start), 1);
        chk("first_valid", 32'(valid), 1);
        chk("first_h", 32'(h_cnt), 0);
        chk("first_v", 32'(v_cnt), 0);
`ifdef VGA_FRAME_CNT_EN
        chk("frame_cnt_first", 32'(frame_cnt), 1);
`endif
      end
      if (i == 6) chk("first_fs_width", 32'(frame_start), 0);
      if (i == 9) chk("second_pixel_h", 32'(h_cnt), 1);
    end

    // Run to pixel 42 (h=12, v=2, inside hsync) and reset between edges.
    repeat (40) step_pixel(w);
    chk("pre_reset_pos", pack_dut(), pack_exp(12, 2, 0, 0, 1, 0));
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Restart must match power-up, then walk one frame through the table.
    step_pixel(w);
    chk("restart_latency", 32'(w), CD);
    kk = 0;
    for (int i = 0; i < 16; i++) begin
      while (kk < tbl[i].k) begin
        step_pixel(w);
        kk++;
      end
      chk($sformatf("vec[%0d]_k%0d", i, tbl[i].k), pack_dut(),
          pack_exp(tbl[i].h, tbl[i].v, tbl[i].vl, tbl[i].hs, tbl[i].vs, tbl[i].fs));
    end
`ifdef VGA_FRAME_CNT_EN
    chk("frame_cnt_second", 32'(frame_cnt), 2);
`endif
    last_fs = cyc;
    @(negedge clk);
    chk("wrap_fs_width", 32'(frame_start), 0);

    // Three more frames free-running: period, valid count and full raster model.
    acc = 1;
    nfs = 0;
    for (kk = 166; kk <= 165 + 3 * HT * VT; kk++) begin
      step_pixel(w);
      chk($sformatf("raster_k%0d", kk), pack_dut(), model(kk));
      if (frame_start) begin
        nfs++;
        chk("frame_period_clks", 32'(cyc - last_fs), HT * VT * CD);
        chk("valid_per_frame", 32'(acc), HD * VD);
        last_fs = cyc;
        acc = 0;
      end
      if (valid) acc++;
    end
    chk("frame_start_count", 32'(nfs), 3);
`ifdef VGA_FRAME_CNT_EN
    chk("frame_cnt_final", 32'(frame_cnt), 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
